// File: rtl/bru_bpred_if.sv
// Fetch/execute-facing bundle of the branch/PC unit: fetch PC, prediction, resolve operands, redirect, counters.
// Latency: n/a (wiring only); the slave side produces prediction and redirect combinationally.
// Backpressure: i_stall holds the fetch PC; a redirect overrides a stall.
interface bru_bpred_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic             i_stall;
  logic [XLEN-1:0]  o_pc;
  logic             o_pred_taken;
  logic [XLEN-1:0]  o_pred_target;
  logic             i_res_valid;
  logic [XLEN-1:0]  i_res_pc;
  logic             i_res_brch;
  logic             i_res_jal;
  logic             i_res_jalr;
  logic [2:0]       i_res_bfunc3;
  logic [XLEN-1:0]  i_res_rs1;
  logic [XLEN-1:0]  i_res_rs2;
  logic [XLEN-1:0]  i_res_imm;
  logic             i_res_pred_taken;
  logic [XLEN-1:0]  i_res_pred_target;
  logic             o_redirect;
  logic [XLEN-1:0]  o_redirect_pc;
  logic [CNT_W-1:0] o_br_cnt;
  logic [CNT_W-1:0] o_mis_cnt;

  // Pipeline side: drives stall and resolve operands, consumes prediction/redirect.
  modport master (
    output i_stall, i_res_valid, i_res_pc, i_res_brch, i_res_jal, i_res_jalr,
           i_res_bfunc3, i_res_rs1, i_res_rs2, i_res_imm, i_res_pred_taken,
           i_res_pred_target,
    input  o_pc, o_pred_taken, o_pred_target, o_redirect, o_redirect_pc,
           o_br_cnt, o_mis_cnt
  );

  // Branch unit side.
  modport slave (
    input  i_stall, i_res_valid, i_res_pc, i_res_brch, i_res_jal, i_res_jalr,
           i_res_bfunc3, i_res_rs1, i_res_rs2, i_res_imm, i_res_pred_taken,
           i_res_pred_target,
    output o_pc, o_pred_taken, o_pred_target, o_redirect, o_redirect_pc,
           o_br_cnt, o_mis_cnt
  );
endinterface

// File: rtl/bru_bpred.sv
// Fetch PC owner with direct-mapped BTB + 2-bit counters; resolves B/J/JALR and redirects on mispredict.
// Latency: prediction combinational from o_pc, redirect same cycle as resolve, BTB write visible next cycle.
// Backpressure: i_stall holds o_pc unless a redirect is raised, which always loads the corrected PC.
module bru_bpred #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(64'h8000_0000),
  parameter int              BTB_IDX_W = 4,
  parameter int              CNT_W     = 32
) (
  input logic         clk,
  input logic         rst,
  bru_bpred_if.slave  bus
);
  localparam int N     = 1 << BTB_IDX_W;
  localparam int TAG_W = XLEN - BTB_IDX_W - 2;

  // BTB storage: control bits are reset, tag/target are qualified by valid.
  logic [N-1:0]     btb_vld;
  logic [N-1:0]     btb_jmp;
  logic [1:0]       btb_ctr [N];
  logic [TAG_W-1:0] btb_tag [N];
  logic [XLEN-1:0]  btb_tgt [N];

  logic [XLEN-1:0]  pc_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mis_cnt_q;

  // Fetch-side lookup
  logic [BTB_IDX_W-1:0] f_idx;
  logic [TAG_W-1:0]     f_tag;
  logic                 f_hit;
  logic                 pred_taken;
  logic [XLEN-1:0]      pred_target;

  assign f_idx       = pc_q[BTB_IDX_W+1:2];
  assign f_tag       = pc_q[XLEN-1:BTB_IDX_W+2];
  assign f_hit       = btb_vld[f_idx] && (btb_tag[f_idx] == f_tag);
  assign pred_taken  = f_hit && (btb_jmp[f_idx] || btb_ctr[f_idx][1]);
  assign pred_target = pred_taken ? btb_tgt[f_idx] : (pc_q + XLEN'(4));

  assign bus.o_pc          = pc_q;
  assign bus.o_pred_taken  = pred_taken;
  assign bus.o_pred_target = pred_target;

  // Resolve-side signals
  logic                 is_ctrl;
  logic [XLEN:0]        diff;
  logic                 eq, lt, ltu, cond;
  logic                 taken;
  logic [XLEN-1:0]      target;
  logic [XLEN-1:0]      actual;
  logic                 mispred;
  logic                 redirect;
  logic [BTB_IDX_W-1:0] r_idx;
  logic [TAG_W-1:0]     r_tag;
  logic                 r_hit;

  // Branch condition, target and mispredict detection for the execute-stage instruction
  always_comb begin
    is_ctrl = bus.i_res_brch | bus.i_res_jal | bus.i_res_jalr;
    // Borrow out of the widened subtract is the unsigned less-than; a zero difference means equal.
    diff    = {1'b0, bus.i_res_rs1} - {1'b0, bus.i_res_rs2};
    ltu     = diff[XLEN];
    eq      = (diff == '0);
    lt      = $signed(bus.i_res_rs1) < $signed(bus.i_res_rs2);
    cond    = 1'b0;
    case (bus.i_res_bfunc3)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt;
      3'b101:  cond = !lt;
      3'b110:  cond = ltu;
      3'b111:  cond = !ltu;
      default: cond = 1'b0;
    endcase
    taken   = (bus.i_res_brch & cond) | bus.i_res_jal | bus.i_res_jalr;
    target  = bus.i_res_jalr ? ((bus.i_res_rs1 + bus.i_res_imm) & ~XLEN'(1))
                             : (bus.i_res_pc + bus.i_res_imm);
    actual  = taken ? target : (bus.i_res_pc + XLEN'(4));
    // A non-control instruction that was predicted taken hit a stale BTB entry.
    if (is_ctrl) begin
      mispred = (taken != bus.i_res_pred_taken) ||
                (taken && (target != bus.i_res_pred_target));
    end else begin
      mispred = bus.i_res_pred_taken;
    end
    redirect = bus.i_res_valid & mispred;
    r_idx    = bus.i_res_pc[BTB_IDX_W+1:2];
    r_tag    = bus.i_res_pc[XLEN-1:BTB_IDX_W+2];
    r_hit    = btb_vld[r_idx] && (btb_tag[r_idx] == r_tag);
  end

  assign bus.o_redirect    = redirect;
  assign bus.o_redirect_pc = actual;
  assign bus.o_br_cnt      = br_cnt_q;
  assign bus.o_mis_cnt     = mis_cnt_q;

  // Fetch PC: redirect beats stall, otherwise follow the prediction
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect) begin
      pc_q <= actual;
    end else if (!bus.i_stall) begin
      pc_q <= pred_target;
    end
  end

  // BTB control bits: train counters on hits, allocate on taken misses, drop stale entries
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_vld <= '0;
      btb_jmp <= '0;
      for (int i = 0; i < N; i++) begin
        btb_ctr[i] <= 2'b01;
      end
    end else if (bus.i_res_valid && is_ctrl) begin
      if (r_hit) begin
        if (taken) begin
          if (btb_ctr[r_idx] != 2'b11) btb_ctr[r_idx] <= btb_ctr[r_idx] + 2'b01;
          btb_jmp[r_idx] <= bus.i_res_jal | bus.i_res_jalr;
        end else if (btb_ctr[r_idx] != 2'b00) begin
          btb_ctr[r_idx] <= btb_ctr[r_idx] - 2'b01;
        end
      end else if (taken) begin
        btb_vld[r_idx] <= 1'b1;
        btb_jmp[r_idx] <= bus.i_res_jal | bus.i_res_jalr;
        btb_ctr[r_idx] <= 2'b10;
      end
    end else if (bus.i_res_valid && bus.i_res_pred_taken && r_hit) begin
      btb_vld[r_idx] <= 1'b0;
    end
  end

  // BTB tag/target: written on every taken control resolve (hit refresh or allocation)
  always_ff @(posedge clk) begin
    if (bus.i_res_valid && is_ctrl && taken) begin
      btb_tag[r_idx] <= r_tag;
      btb_tgt[r_idx] <= target;
    end
  end

  // Performance counters, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (bus.i_res_valid && is_ctrl && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + CNT_W'(1);
      if (redirect && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: doc/bru_bpred.md
Name: bru_bpred

Overview:
Parametrised next-generation branch/PC unit. It owns the fetch PC register and predicts the next PC each cycle from a direct-mapped BTB with 2-bit saturating counters. It resolves B/J/JALR instructions from the execute stage with the existing BEQ..BGEU compare rules, and drives a redirect/flush on mispredict. Fetch consumes o_pc/o_pred_*; execute returns the prediction alongside operands for checking.

Parameters:
XLEN, 64, datapath/PC width
RESET_PC, 64'h80000000, PC value after reset
BTB_IDX_W, 4, log2 of BTB entry count (16 entries)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_stall  in  1  hold PC (fetch stalled)
o_pc  out  XLEN  current fetch PC
o_pred_taken  out  1  prediction for o_pc
o_pred_target  out  XLEN  predicted next PC for o_pc (o_pc+4 when not taken)
i_res_valid  in  1  execute-stage instruction valid
i_res_pc  in  XLEN  PC of resolving instruction
i_res_brch  in  1  B-type
i_res_jal  in  1  JAL
i_res_jalr  in  1  JALR
i_res_bfunc3  in  3  branch funct3
i_res_rs1  in  XLEN  bypassed rs1 data
i_res_rs2  in  XLEN  bypassed rs2 data
i_res_imm  in  XLEN  sign-extended immediate
i_res_pred_taken  in  1  prediction carried with the instruction
i_res_pred_target  in  XLEN  predicted target carried with the instruction
o_redirect  out  1  mispredict; flush younger stages
o_redirect_pc  out  XLEN  corrected next PC
o_br_cnt  out  CNT_W  resolved control-flow instructions
o_mis_cnt  out  CNT_W  mispredicts

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset effects: o_pc=RESET_PC; all BTB valid bits cleared; counters=2'b01; o_br_cnt=o_mis_cnt=0.
- BTB entry fields: valid, tag=pc[XLEN-1:BTB_IDX_W+2], target[XLEN], is_jump, ctr[2].
- BTB index: pc[BTB_IDX_W+1:2]. pc[1:0] is ignored.
- Lookup (combinational from o_pc): hit = valid & tag match.
- o_pred_taken = hit & (is_jump | ctr[1]). o_pred_target = o_pred_taken ? target : o_pc+4.
- Resolve (combinational, i_res_valid only):
  - BEQ: rs1==rs2. BNE: rs1!=rs2. BLT/BGE: signed compare. BLTU/BGEU: unsigned compare via XLEN+1-bit subtract borrow.
  - funct3 010/011 gives not taken.
  - taken = (brch & cond) | jal | jalr.
  - target = jalr ? ((rs1+imm) & ~1) : res_pc+imm.
  - actual = taken ? target : res_pc+4.
- Mispredict = (taken != pred_taken) | (taken & target != pred_target).
  - Only for valid instructions with brch|jal|jalr.
  - Non-control valid instruction: mispredict iff pred_taken=1.
- Redirect outputs: o_redirect = i_res_valid & mispredict, same cycle. o_redirect_pc = actual (res_pc+4 for non-control).
- PC update, priority order:
  - rst
  - o_redirect: o_pc <= o_redirect_pc, even when i_stall
  - !i_stall: o_pc <= o_pred_target
  - else hold.
- BTB update at clock edge, when i_res_valid & (brch|jal|jalr):
  - Tag hit at res index: ctr saturating ++ if taken, -- if not. On taken, also write target and is_jump=jal|jalr.
  - Miss and taken: allocate/overwrite entry: valid=1, tag, target, is_jump, ctr=2'b10.
  - Miss and not taken: no change.
  - Non-control spurious hit (mispredict): clear that entry's valid.
- Read-during-write: a lookup in the same cycle as a write to the same index sees old contents. The new contents are visible next cycle.
- Counters: o_br_cnt increments per resolved control instruction. o_mis_cnt increments per o_redirect. Both saturate at all-ones (no wrap).
- Timing: arithmetic is modulo 2^XLEN; PC+4 wrap at top of address space is allowed. Single-cycle lookup, zero-latency redirect, one-cycle BTB write latency.

Test Plan:
- Reset: rst=1 one cycle, no resolves, i_stall=0 -> o_pc=0x80000000, then 0x80000004, 0x80000008. o_pred_taken=0. Counters 0.
- Cold BEQ: res_pc=0x80000010, rs1=rs2=5, imm=0x20, pred_taken=0 -> o_redirect=1, o_redirect_pc=0x80000030, next o_pc=0x80000030. Next fetch of 0x80000010 predicts taken to 0x80000030 (ctr=10).
- Counter training: same branch resolved not-taken twice after allocation -> ctr 10->01->00. Third fetch predicts not taken. Further not-taken holds ctr=00.
- JALR: rs1=0x80001003, imm=4, pred_taken=0 -> target 0x80001006 (bit0 cleared), redirect. Later predicted taken regardless of ctr.
- Signed vs unsigned: rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1 -> BLT taken, BLTU not taken, BGEU taken. Redirect matches each.
- Stall+redirect: i_stall=1 with o_redirect=1 -> o_pc takes o_redirect_pc. Stall alone holds o_pc. Counter at 0xFFFFFFFF stays saturated.
